proc_alu: RTL and testbench
===========================

// Module: proc_alu
// PURPOSE
//  Parametrised, registered ALU for the processor datapath; successor to the single 2-input AND gate
//  with LED indicator. Accepts one operation per handshake and returns a registered result plus Z/N/C/V flags.
//  Flags also drive the front-panel LEDs.
//  Sits between the register-file read ports and the write-back stage.
// PARAMETERS
//  WIDTH    8                 data width; power of 2, >= 4
//  SHAMT_W  $clog2(WIDTH)     shift-amount bits taken from b
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       operation offered
//  in_ready   out  1       operation accepted when in_valid && in_ready
//  op         in   3       opcode (see BEHAVIOUR)
//  a, b       in   WIDTH   operands
//  out_valid  out  1       result/flags valid
//  out_ready  in   1       consumer takes result when out_valid && out_ready
//  result     out  WIDTH   registered result
//  flags      out  4       {V,C,N,Z}, registered with result
//  busy       out  1       multi-cycle op in progress (0 when ALU_MUL_EN undefined)
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, result=0, flags=0, busy=0; FSM->IDLE.
//  - Reset mid-operation: any in-flight op is discarded.
//  - Handshake:
//    - in_ready = (state==IDLE) && (!out_valid || out_ready).
//    - Single output register, no skid buffer.
//    - Accept and drain in the same cycle is legal: the new result loads next edge and out_valid stays 1.
//    - While out_valid && !out_ready, result and flags hold stable.
//  - Latency: 1 cycle (accept at edge N -> out_valid at edge N+1) for ops 000-110.
//  - Ops:
//    - 000 AND; 001 OR; 010 XOR; 011 NOT a; 100 a+b; 101 a-b.
//    - 110 SHL a by b[SHAMT_W-1:0].
//    - 111: SHR logical (no macro) or MUL (ALU_MUL_EN).
//  - Arithmetic is WIDTH bits, wrap-around, no saturation.
//  - Flags:
//    - Z = (result==0); N = result[WIDTH-1].
//    - C: ADD carry-out; SUB borrow (a<b unsigned); SHL/SHR last bit shifted out (0 if amount 0);
//      MUL upper half nonzero; logic ops 0.
//    - V: signed overflow for ADD/SUB only, else 0.
//  - FSM: IDLE -> (accept op 111 w/ MUL) -> MUL (WIDTH cycles) -> DONE (1 cycle, loads output reg) -> IDLE.
//    All other ops stay in IDLE.
// CONFIGURATION
//  ALU_MUL_EN
//    - Defined: op 111 = unsigned MUL, low WIDTH bits to result.
//      - Shift-add, one bit per cycle; out_valid WIDTH+1 cycles after accept.
//      - busy=1 in MUL/DONE; in_ready=0 meanwhile.
//    - Undefined: op 111 = 1-cycle SHR; no MUL/DONE states; busy tied 0.
// STRUCTURE
//  - Package proc_alu_pkg:
//    - op_e enum (OP_AND..OP_X7).
//    - flag indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
//    - state_e {IDLE, MUL, DONE}.
//  - Sub-module proc_alu_mul: shift-add sequencer (start, a, b -> done, prod[2*WIDTH-1:0]).
//    Instantiated only under ALU_MUL_EN.
//  - Combinational op decode and output register stay in proc_alu.
// TESTING
//  AND a=F0 b=3C, out_ready=1 -> next cycle result=30, flags=0000, out_valid=1 for 1 cycle.
//  ADD 7F+01 -> result=80, V=1 C=0 N=1 Z=0; SUB 00-01 -> FF, C=1 N=1 V=0.
//  SHL a=81 b=01 -> 02, C=1; SHR a=01 b=01 -> 00, Z=1 C=1 (no macro).
//  Backpressure: out_ready=0 for 3 cycles after XOR result -> result/flags stable, in_ready=0;
//    out_ready=1 with new op offered -> both transfer same edge, out_valid stays 1.
//  ALU_MUL_EN, WIDTH=8: 0F*11 -> FF, C=0, out_valid exactly 9 cycles after accept, busy=1 throughout;
//    10*10 -> 00, Z=1 C=1.
//  rst_n pulsed low mid-MUL -> out_valid=0, busy=0 immediately; next ADD 02+03 -> 05 after 1 cycle.

Source files
------------

// File: rtl/proc_alu_pkg.sv
// rtl/proc_alu_pkg.sv - shared opcode, flag-index and FSM-state definitions for proc_alu
package proc_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SHL = 3'b110,
    OP_X7  = 3'b111
  } op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/proc_alu_if.sv
// rtl/proc_alu_if.sv - operation/result handshake bundle between datapath and proc_alu
interface proc_alu_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags, busy
  );

endinterface

// File: rtl/proc_alu_mul.sv
// rtl/proc_alu_mul.sv - unsigned shift-add multiplier, one multiplier bit per cycle
module proc_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      cnt     <= CNT_W'(WIDTH);
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) running <= 1'b0;
    end
  end

  // done marks the final step; prod is complete after this edge
  assign done = running && (cnt == CNT_W'(1));
  assign prod = acc;

endmodule

// File: rtl/proc_alu.sv
// rtl/proc_alu.sv - registered ALU with Z/N/C/V flags and valid/ready handshake
// ALU_MUL_EN: op 111 becomes a multi-cycle unsigned multiply instead of logical shift right
module proc_alu
  import proc_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  proc_alu_if.slave  bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_e             state;
  state_e             state_next;
  op_e                op;
  logic               accept;
  logic               load;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH-1:0]   res_d;
  logic               c_d;
  logic               v_d;
  logic [3:0]         flags_d;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic [3:0]         flags;

  assign op           = op_e'(bus.op);
  assign bus.in_ready = (state == IDLE) && (!out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Extra top bit carries carry/borrow out; for shifts it catches the last bit shifted out
  assign shamt = bus.b[SHAMT_W-1:0];
  assign add_w = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_w = {1'b0, bus.a} - {1'b0, bus.b};
  assign shl_w = {1'b0, bus.a} << shamt;
  assign shr_w = {bus.a, 1'b0} >> shamt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_NOT: alu_res = ~bus.a;
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_X7: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;

  assign mul_start = accept && (op == OP_X7);

  proc_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mul_done),
    .prod  (prod)
  );

  assign load     = (accept && (op != OP_X7)) || (state == DONE);
  assign bus.busy = (state != IDLE);
`else
  assign load     = accept;
  assign bus.busy = 1'b0;
`endif

  always_comb begin
    res_d = alu_res;
    c_d   = alu_c;
    v_d   = alu_v;
`ifdef ALU_MUL_EN
    if (state == DONE) begin
      res_d = prod[WIDTH-1:0];
      c_d   = |prod[2*WIDTH-1:WIDTH];
      v_d   = 1'b0;
    end
`endif
    flags_d         = '0;
    flags_d[FLAG_Z] = (res_d == '0);
    flags_d[FLAG_N] = res_d[WIDTH-1];
    flags_d[FLAG_C] = c_d;
    flags_d[FLAG_V] = v_d;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
`ifdef ALU_MUL_EN
        if (accept && (op == OP_X7)) state_next = MUL;
`endif
      end
`ifdef ALU_MUL_EN
      MUL:  if (mul_done) state_next = DONE;
      DONE: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Single output register: a new load may coincide with the consumer draining the old one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= res_d;
      flags     <= flags_d;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.flags     = flags;

endmodule

// File: tb/tb_proc_alu.sv
// tb/tb_proc_alu.sv - directed-vector bench for proc_alu (WIDTH=8), default and ALU_MUL_EN builds
module tb_proc_alu;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  proc_alu_if #(.WIDTH(8)) bus ();

  proc_alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_r, input logic [3:0] exp_f);
    check({tag, ".valid"},  32'(bus.out_valid), 32'd1);
    check({tag, ".result"}, 32'(bus.result),    32'(exp_r));
    check({tag, ".flags"},  32'(bus.flags),     32'(exp_f));
  endtask

  task automatic offer(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] exp_r, input logic [3:0] exp_f);
    @(negedge clk);
    offer(o, x, y);
    #1 check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check_out(tag, exp_r, exp_f);
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp_r, input logic [3:0] exp_f);
    @(negedge clk);
    offer(3'b111, x, y);
    #1 check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check({tag, ".wait_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, ".busy"},       32'(bus.busy),      32'd1);
      check({tag, ".in_ready"},   32'(bus.in_ready),  32'd0);
    end
    @(negedge clk);
    check_out(tag, exp_r, exp_f);
    check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.result",    32'(bus.result),    32'd0);
    check("rst.flags",     32'(bus.flags),     32'd0);
    check("rst.busy",      32'(bus.busy),      32'd0);
    check("rst.in_ready",  32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;

    // flags literal order is {V,C,N,Z}
    run_op("and", 3'b000, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    @(negedge clk);
    check("and.one_cycle", 32'(bus.out_valid), 32'd0);
    run_op("or",      3'b001, 8'hA0, 8'h05, 8'hA5, 4'b0010);
    run_op("xor_z",   3'b010, 8'hF0, 8'hF0, 8'h00, 4'b0001);
    run_op("not",     3'b011, 8'h0F, 8'h00, 8'hF0, 4'b0010);
    run_op("add_ov",  3'b100, 8'h7F, 8'h01, 8'h80, 4'b1010);
    run_op("add_c",   3'b100, 8'hFF, 8'h01, 8'h00, 4'b0101);
    run_op("sub_b",   3'b101, 8'h00, 8'h01, 8'hFF, 4'b0110);
    run_op("sub_ov",  3'b101, 8'h80, 8'h01, 8'h7F, 4'b1000);
    run_op("shl_c",   3'b110, 8'h81, 8'h01, 8'h02, 4'b0100);
    run_op("shl_0",   3'b110, 8'h81, 8'h00, 8'h81, 4'b0010);
    run_op("shl_msk", 3'b110, 8'h01, 8'h09, 8'h02, 4'b0000);
`ifndef ALU_MUL_EN
    run_op("shr_c",   3'b111, 8'h01, 8'h01, 8'h00, 4'b0101);
    run_op("shr_7",   3'b111, 8'h80, 8'h07, 8'h01, 4'b0000);
`endif

    // Backpressure: XOR result stalls, a pending ADD must wait, then both move on one edge
    @(negedge clk);
    bus.out_ready = 1'b0;
    offer(3'b010, 8'h3C, 8'h0F);
    @(posedge clk);
    #1 offer(3'b100, 8'h02, 8'h03);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_out("bp.hold", 8'h33, 4'b0000);
      check("bp.in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1 check("bp.in_ready_high", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check_out("bp.next", 8'h05, 4'b0000);
    @(negedge clk);
    check("bp.drained", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while a result is held
    @(negedge clk);
    bus.out_ready = 1'b0;
    offer(3'b001, 8'h12, 8'h40);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check_out("rst2.pre", 8'h52, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    check("rst2.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst2.result",    32'(bus.result),    32'd0);
    check("rst2.flags",     32'(bus.flags),     32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    run_op("rst2.add", 3'b100, 8'h02, 8'h03, 8'h05, 4'b0000);

`ifdef ALU_MUL_EN
    mul_op("mul_c",  8'h10, 8'h10, 8'h00, 4'b0101);
    mul_op("mul_ff", 8'h0F, 8'h11, 8'hFF, 4'b0010);

    // Reset in the middle of a multiply discards it
    @(negedge clk);
    offer(3'b111, 8'h0F, 8'h11);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst.busy_pre", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst.busy",      32'(bus.busy),      32'd0);
    check("mrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst.result",    32'(bus.result),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mrst.add", 3'b100, 8'h02, 8'h03, 8'h05, 4'b0000);
    check("mrst.busy_after", 32'(bus.busy), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
